// File: rtl/mem_wb_stage_reg.sv
// MEM->WB pipeline register for the five-stage MIPS core.
// Holds the memory-stage results for one cycle before register-file write-back.
// It supports stall and flush, a valid bit, and write-enable gating.
// It also keeps saturating retire/bubble performance counters.
module mem_wb_stage_reg #(
    parameter int              DATA_W        = 32,
    parameter int              REG_AW        = 5,
    parameter int              PC_W          = 32,
    parameter logic [PC_W-1:0] RESET_PC      = PC_W'(32'h00003000),
    parameter bit              FLUSH_KEEP_PC = 1'b0,
    parameter int              CNT_W         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              stall,
    input  logic              cnt_clr,
    input  logic              validM,
    input  logic [DATA_W-1:0] rdataM,
    input  logic [DATA_W-1:0] addM,
    input  logic [REG_AW-1:0] rt_rdM,
    input  logic              weM,
    input  logic [PC_W-1:0]   PCM,
    output logic              validW,
    output logic [DATA_W-1:0] rdataW,
    output logic [DATA_W-1:0] addW,
    output logic [REG_AW-1:0] rt_rdW,
    output logic              weW,
    output logic [PC_W-1:0]   PCW,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] add_q,   add_d;
    logic [REG_AW-1:0] rtRd_q,  rtRd_d;
    logic              we_q,    we_d;
    logic [PC_W-1:0]   pc_q,    pc_d;
    logic [CNT_W-1:0]  retireCnt_q, retireCnt_d;
    logic [CNT_W-1:0]  bubbleCnt_q, bubbleCnt_d;
    logic              retireEvt;

    // Stage next-state: flush beats stall, stall beats a normal load
    always_comb begin
        valid_d = valid_q;
        rdata_d = rdata_q;
        add_d   = add_q;
        rtRd_d  = rtRd_q;
        we_d    = we_q;
        pc_d    = pc_q;
        if (clr) begin
            valid_d = 1'b0;
            rdata_d = '0;
            add_d   = '0;
            rtRd_d  = '0;
            we_d    = 1'b0;
            pc_d    = FLUSH_KEEP_PC ? pc_q : RESET_PC;
        end else if (!stall) begin
            valid_d = validM;
            rdata_d = rdataM;
            add_d   = addM;
            rtRd_d  = rt_rdM;
            we_d    = weM;
            pc_d    = PCM;
        end
    end

    // Counter next-state: each edge is either a retire or a bubble; counts saturate
    always_comb begin
        retireEvt   = !clr && !stall && validM;
        retireCnt_d = retireCnt_q;
        bubbleCnt_d = bubbleCnt_q;
        if (cnt_clr) begin
            retireCnt_d = '0;
            bubbleCnt_d = '0;
        end else if (retireEvt) begin
            if (retireCnt_q != {CNT_W{1'b1}}) begin
                retireCnt_d = retireCnt_q + CNT_W'(1);
            end
        end else begin
            if (bubbleCnt_q != {CNT_W{1'b1}}) begin
                bubbleCnt_d = bubbleCnt_q + CNT_W'(1);
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= 1'b0;
            rdata_q     <= '0;
            add_q       <= '0;
            rtRd_q      <= '0;
            we_q        <= 1'b0;
            pc_q        <= RESET_PC;
            retireCnt_q <= '0;
            bubbleCnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            rdata_q     <= rdata_d;
            add_q       <= add_d;
            rtRd_q      <= rtRd_d;
            we_q        <= we_d;
            pc_q        <= pc_d;
            retireCnt_q <= retireCnt_d;
            bubbleCnt_q <= bubbleCnt_d;
        end
    end

    // Bubbles and writes to $0 must never reach the register file
    assign weW        = we_q && valid_q && (rtRd_q != '0);
    assign validW     = valid_q;
    assign rdataW     = rdata_q;
    assign addW       = add_q;
    assign rt_rdW     = rtRd_q;
    assign PCW        = pc_q;
    assign retire_cnt = retireCnt_q;
    assign bubble_cnt = bubbleCnt_q;

endmodule

// File: tb/tb_mem_wb_stage_reg.sv
// Self-checking bench for mem_wb_stage_reg.
// It uses two instances: instance 0 has default parameters.
// Instance 1 has FLUSH_KEEP_PC=1 and CNT_W=4, so it also exercises counter saturation.
module tb_mem_wb_stage_reg;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clr = 1'b0, stall = 1'b0, cnt_clr = 1'b0;
    logic        validM = 1'b0, weM = 1'b0;
    logic [31:0] rdataM = '0, addM = '0, PCM = '0;
    logic [4:0]  rt_rdM = '0;

    logic        validW0, weW0, validW1, weW1;
    logic [31:0] rdataW0, addW0, PCW0, rdataW1, addW1, PCW1;
    logic [4:0]  rt_rdW0, rt_rdW1;
    logic [31:0] retire0, bubble0;
    logic [3:0]  retire1, bubble1;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model state, shared data fields plus per-instance PC and counters
    logic        mValid, mWe;
    logic [31:0] mRdata, mAdd;
    logic [4:0]  mRt;
    logic [31:0] mPc[2];
    longint      mRetire[2], mBubble[2];
    longint      cntMax[2] = '{64'hFFFF_FFFF, 64'd15};
    bit          keepPc[2] = '{1'b0, 1'b1};
    localparam logic [31:0] RST_PC = 32'h0000_3000;

    always #5 clk = ~clk;

    mem_wb_stage_reg dut0 (
        .clk(clk), .reset(reset), .clr(clr), .stall(stall), .cnt_clr(cnt_clr),
        .validM(validM), .rdataM(rdataM), .addM(addM), .rt_rdM(rt_rdM), .weM(weM), .PCM(PCM),
        .validW(validW0), .rdataW(rdataW0), .addW(addW0), .rt_rdW(rt_rdW0), .weW(weW0),
        .PCW(PCW0), .retire_cnt(retire0), .bubble_cnt(bubble0)
    );

    mem_wb_stage_reg #(.FLUSH_KEEP_PC(1'b1), .CNT_W(4)) dut1 (
        .clk(clk), .reset(reset), .clr(clr), .stall(stall), .cnt_clr(cnt_clr),
        .validM(validM), .rdataM(rdataM), .addM(addM), .rt_rdM(rt_rdM), .weM(weM), .PCM(PCM),
        .validW(validW1), .rdataW(rdataW1), .addW(addW1), .rt_rdW(rt_rdW1), .weW(weW1),
        .PCW(PCW1), .retire_cnt(retire1), .bubble_cnt(bubble1)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    endtask

    task automatic modelReset();
        mValid = 1'b0; mWe = 1'b0; mRdata = '0; mAdd = '0; mRt = '0;
        for (int i = 0; i < 2; i++) begin
            mPc[i] = RST_PC; mRetire[i] = 0; mBubble[i] = 0;
        end
    endtask

    task automatic modelEdge();
        bit retire;
        retire = !clr && !stall && validM;
        if (clr) begin
            mValid = 1'b0; mWe = 1'b0; mRdata = '0; mAdd = '0; mRt = '0;
            for (int i = 0; i < 2; i++) if (!keepPc[i]) mPc[i] = RST_PC;
        end else if (!stall) begin
            mValid = validM; mWe = weM; mRdata = rdataM; mAdd = addM; mRt = rt_rdM;
            for (int i = 0; i < 2; i++) mPc[i] = PCM;
        end
        for (int i = 0; i < 2; i++) begin
            if (cnt_clr) begin
                mRetire[i] = 0; mBubble[i] = 0;
            end else if (retire) begin
                if (mRetire[i] < cntMax[i]) mRetire[i]++;
            end else begin
                if (mBubble[i] < cntMax[i]) mBubble[i]++;
            end
        end
    endtask

    task automatic checkAll(input string pfx);
        logic expWe;
        expWe = mWe && mValid && (mRt != 0);
        checkOutput({pfx, "_i0_valid"}, 64'(validW0), 64'(mValid));
        checkOutput({pfx, "_i0_rdata"}, 64'(rdataW0), 64'(mRdata));
        checkOutput({pfx, "_i0_add"},   64'(addW0),   64'(mAdd));
        checkOutput({pfx, "_i0_rt"},    64'(rt_rdW0), 64'(mRt));
        checkOutput({pfx, "_i0_we"},    64'(weW0),    64'(expWe));
        checkOutput({pfx, "_i0_pc"},    64'(PCW0),    64'(mPc[0]));
        checkOutput({pfx, "_i0_ret"},   64'(retire0), 64'(mRetire[0]));
        checkOutput({pfx, "_i0_bub"},   64'(bubble0), 64'(mBubble[0]));
        checkOutput({pfx, "_i1_valid"}, 64'(validW1), 64'(mValid));
        checkOutput({pfx, "_i1_rdata"}, 64'(rdataW1), 64'(mRdata));
        checkOutput({pfx, "_i1_add"},   64'(addW1),   64'(mAdd));
        checkOutput({pfx, "_i1_rt"},    64'(rt_rdW1), 64'(mRt));
        checkOutput({pfx, "_i1_we"},    64'(weW1),    64'(expWe));
        checkOutput({pfx, "_i1_pc"},    64'(PCW1),    64'(mPc[1]));
        checkOutput({pfx, "_i1_ret"},   64'(retire1), 64'(mRetire[1]));
        checkOutput({pfx, "_i1_bub"},   64'(bubble1), 64'(mBubble[1]));
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] rd, input logic [31:0] ad,
                                 input logic [4:0] rt, input logic we, input logic [31:0] pc,
                                 input logic c, input logic s, input logic cc, input string tag);
        validM = v; rdataM = rd; addM = ad; rt_rdM = rt; weM = we; PCM = pc;
        clr = c; stall = s; cnt_clr = cc;
        @(posedge clk);
        modelEdge();
        #1;
        checkAll(tag);
    endtask

    initial begin
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset");
        @(negedge clk);
        reset = 1'b0;

        // Load, then three stalls with changing inputs
        applyStimulus(1, 32'hDEADBEEF, 32'h10, 5'd8, 1, 32'h3004, 0, 0, 0, "load");
        checkOutput("tp2_we", 64'(weW0), 64'd1);
        checkOutput("tp2_retire", 64'(retire0), 64'd1);
        for (int i = 0; i < 3; i++)
            applyStimulus(1, $urandom, $urandom, 5'(i + 1), 1, $urandom, 0, 1, 0, "stall");
        checkOutput("tp2_rdata_held", 64'(rdataW0), 64'hDEADBEEF);
        checkOutput("tp2_bubble", 64'(bubble0), 64'd3);

        // Flush wins over stall; the two PC flush flavours diverge
        applyStimulus(1, 32'h1, 32'h2, 5'd3, 1, 32'h3008, 0, 0, 0, "preflush");
        applyStimulus(1, 32'h5, 32'h6, 5'd7, 1, 32'h300C, 1, 1, 0, "flush");
        checkOutput("tp3_pc_reset", 64'(PCW0), 64'h3000);
        checkOutput("tp3_pc_keep", 64'(PCW1), 64'h3008);
        checkOutput("tp3_valid", 64'(validW0), 64'd0);

        // Write-enable gating for $0 and invalid instructions
        applyStimulus(1, 32'h11, 32'h22, 5'd0, 1, 32'h3010, 0, 0, 0, "rt0");
        checkOutput("tp4_we_rt0", 64'(weW0), 64'd0);
        applyStimulus(0, 32'h33, 32'h44, 5'd5, 1, 32'h3014, 0, 0, 0, "inval");
        checkOutput("tp4_we_inval", 64'(weW0), 64'd0);

        // Saturation of the narrow counter, then clear beats a retire event
        for (int i = 0; i < 20; i++)
            applyStimulus(1, $urandom, $urandom, 5'($urandom), 1'($urandom), $urandom, 0, 0, 0, "sat");
        checkOutput("tp5_sat", 64'(retire1), 64'd15);
        applyStimulus(1, $urandom, $urandom, 5'd9, 1, $urandom, 0, 0, 1, "cntclr");
        checkOutput("tp5_cntclr", 64'(retire1), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0), $urandom, $urandom,
                          ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), 1'($urandom), $urandom,
                          ($urandom_range(0, 15) == 0), ($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 31) == 0), "rand");
        end

        // Asynchronous reset between edges while stalled
        applyStimulus(1, 32'hCAFEF00D, 32'h40, 5'd12, 1, 32'h3100, 0, 0, 0, "prerst");
        applyStimulus(1, 32'h0, 32'h0, 5'd1, 1, 32'h3104, 0, 1, 0, "rststall");
        #3;
        reset = 1'b1;
        #1;
        modelReset();
        checkAll("asyncrst");
        checkOutput("tp6_pc", 64'(PCW0), 64'h3000);
        #2;
        reset = 1'b0;
        for (int i = 0; i < 30; i++)
            applyStimulus(($urandom_range(0, 3) != 0), $urandom, $urandom, 5'($urandom),
                          1'($urandom), $urandom, ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 4) == 0), 1'b0, "post");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage_reg.md
Name: mem_wb_stage_reg

Overview:
Parametrised MEM→WB pipeline register for the five-stage MIPS core. It is the successor to the fixed 32-bit MEM/WB latch and adds:
- stall hold and flush with a defined priority;
- a valid bit, and write-enable gating so bubbles and $0 writes never reach the register file;
- an optional PC-preserving flush, for exception EPC capture;
- saturating retire and bubble performance counters.

It sits between the data-memory stage and the register-file write port.

Parameters:
DATA_W, 32, width of load data and ALU result fields
REG_AW, 5, register-number width
PC_W, 32, PC width
RESET_PC, 32'h00003000, PC value loaded by reset
FLUSH_KEEP_PC, 0, 1 = clr leaves PCW unchanged; 0 = clr loads RESET_PC
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-high reset
clr  in  1  synchronous flush: insert a bubble
stall  in  1  hold all stage contents this cycle
cnt_clr  in  1  synchronous clear of both counters
validM  in  1  MEM-stage instruction valid
rdataM  in  DATA_W  load data from data memory
addM  in  DATA_W  ALU result / address from MEM stage
rt_rdM  in  REG_AW  destination register number
weM  in  1  MEM-stage register write request
PCM  in  PC_W  MEM-stage PC
validW  out  1  WB-stage valid
rdataW  out  DATA_W  latched load data
addW  out  DATA_W  latched ALU result
rt_rdW  out  REG_AW  latched destination
weW  out  1  gated write enable = we_q & validW & (rt_rdW != 0)
PCW  out  PC_W  latched PC
retire_cnt  out  CNT_W  count of instructions latched valid
bubble_cnt  out  CNT_W  count of edges that latched no instruction

Behaviour:
- Asynchronous reset (reset=1, any time, including mid-stall or mid-flush):
  - validW=0, rdataW=0, addW=0, rt_rdW=0, internal we_q=0, so weW=0;
  - PCW=RESET_PC;
  - retire_cnt=0, bubble_cnt=0.
  - Reset release takes effect on the next rising edge.
- Stage update priority on each rising edge, reset deasserted: clr > stall > load.
  - clr=1 (wins even when stall=1):
    - validW←0, rdataW←0, addW←0, rt_rdW←0, we_q←0;
    - PCW←PCW if FLUSH_KEEP_PC=1, else RESET_PC.
  - stall=1, clr=0: every stage register holds its value.
  - otherwise (load): validW←validM; rdataW, addW, rt_rdW, we_q, PCW ← their M-side inputs.
    - validM=0 still latches the data fields, but weW is forced to 0 by gating.
- Latency: exactly one cycle from M inputs to W outputs on a load edge.
- weW is purely combinational from registered state; there is no path from M inputs to any W output within a cycle.
- Counter event per edge, reset deasserted: `retire_evt = !clr & !stall & validM`; `bubble_evt = !retire_evt`.
- Counter update priority, evaluated independently of stage priority:
  - cnt_clr=1: both counters ←0 and that edge's event is discarded.
  - otherwise: the evt counter increments by 1, saturating at all-ones (no wrap).
- Counters keep counting during stall: a stall edge counts as a bubble.
- Per edge, exactly one counter advances unless either is saturated or cnt_clr=1.
- Field widths come only from parameters; no sign extension or truncation is applied.

Test Plan:
1. Reset with RESET_PC=0x3000, FLUSH_KEEP_PC=0 → all W outputs 0, PCW=0x3000, both counters 0, weW=0.
2. Load, then stall:
   - first edge: validM=1, rdataM=0xDEADBEEF, addM=0x10, rt_rdM=8, weM=1, PCM=0x3004 → next cycle W outputs match, weW=1, retire_cnt=1;
   - then stall=1 for 3 edges with changed M inputs → W outputs unchanged, bubble_cnt=3.
3. Flush:
   - load PCM=0x3008, then clr=1 and stall=1 on the same edge → validW=0, weW=0, rt_rdW=0, PCW=0x3000;
   - repeat with FLUSH_KEEP_PC=1 → PCW stays 0x3008.
4. Write-enable gating:
   - validM=1, weM=1, rt_rdM=0 → weW=0 and retire_cnt increments;
   - validM=0, weM=1, rt_rdM=5 → weW=0 and bubble_cnt increments.
5. Counter saturation, CNT_W=4:
   - 20 valid loads → retire_cnt saturates at 15;
   - cnt_clr=1 together with validM=1 → retire_cnt=0 next cycle.
6. Reset mid-operation: assert reset asynchronously between edges during a stall → outputs take reset values immediately, without waiting for a clk edge.
